unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/jogo_pkg.sv | 19 +
 rtl/unidade_controle_if.sv | 24 ++
 rtl/debounce_botoes.sv | 54 +++++
 rtl/unidade_controle.sv | 111 +++++++++++
 tb/tb_unidade_controle.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/jogo_pkg.sv
// Shared types and constants for the light-toggle puzzle controller.
package jogo_pkg;
  localparam int N_BOTOES     = 8;
  localparam int N_NIVEIS_DEF = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LIMPA   = 3'd1,
    JOGANDO = 3'd2,
    AGUARDA = 3'd3,
    CHECA   = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // Isolates the lowest set bit; zero in gives zero out.
  function automatic logic [N_BOTOES-1:0] lsb_onehot(input logic [N_BOTOES-1:0] v);
    return v & (~v + {{(N_BOTOES-1){1'b0}}, 1'b1});
  endfunction
endpackage

// File: rtl/unidade_controle_if.sv
// Bundle between the game controller (slave) and its environment (master).
interface unidade_controle_if;
  import jogo_pkg::*;

  logic                iniciar;
  logic [N_BOTOES-1:0] botoes_raw;
  logic                nivel_concluido;
  logic [N_BOTOES-1:0] botoes;
  logic                limpa;
  logic [2:0]          nivel;
  logic [7:0]          jogadas;
  logic                venceu;
  logic [2:0]          estado;

  modport master (
    output iniciar, botoes_raw, nivel_concluido,
    input  botoes, limpa, nivel, jogadas, venceu, estado
  );

  modport slave (
    input  iniciar, botoes_raw, nivel_concluido,
    output botoes, limpa, nivel, jogadas, venceu, estado
  );
endinterface

// File: rtl/debounce_botoes.sv
// Synchronises, debounces and rising-edge detects the raw push-buttons.
module debounce_botoes
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] i_raw,
  output logic [N_BOTOES-1:0] o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [N_BOTOES-1:0] r_sync1, r_sync2;
  logic [N_BOTOES-1:0] r_samp, r_estavel, r_estavel_d;
  logic [CW-1:0]       r_cnt;
  logic                w_tick;
  logic [N_BOTOES-1:0] w_igual;

  assign w_tick  = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_igual = ~(r_sync2 ^ r_samp);
  assign o_rise  = r_estavel & ~r_estavel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  // A bit only moves once two consecutive tick samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp      <= '0;
      r_estavel   <= '0;
      r_estavel_d <= '0;
    end else begin
      r_estavel_d <= r_estavel;
      if (w_tick) begin
        r_samp    <= r_sync2;
        r_estavel <= (r_estavel & ~w_igual) | (r_sync2 & w_igual);
      end
    end
  end
endmodule

// File: rtl/unidade_controle.sv
// Game controller: button arbitration, level sequencing and matrix clear/toggle requests.
module unidade_controle
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int N_NIVEIS        = N_NIVEIS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  unidade_controle_if.slave  bus
);
  localparam logic [2:0] ULTIMO = 3'(N_NIVEIS - 1);

  estado_t             r_estado;
  logic [2:0]          r_nivel;
  logic [7:0]          r_jog;
  logic                r_venceu;
  logic [N_BOTOES-1:0] r_botoes;
  logic                r_limpa;
  logic [N_BOTOES-1:0] r_pend;
  logic                r_espera;

  logic [N_BOTOES-1:0] w_rise;
  logic [N_BOTOES-1:0] w_sel;

  debounce_botoes #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_raw  (bus.botoes_raw),
    .o_rise (w_rise)
  );

  assign w_sel = lsb_onehot(r_pend);

  // Pending presses survive the AGUARDA/CHECA round trip so simultaneous
  // presses are serviced one per JOGANDO visit; new edges latch only in JOGANDO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
      r_nivel  <= '0;
      r_jog    <= '0;
      r_venceu <= 1'b0;
      r_botoes <= '0;
      r_limpa  <= 1'b0;
      r_pend   <= '0;
      r_espera <= 1'b0;
    end else begin
      r_botoes <= '0;
      r_limpa  <= 1'b0;
      case (r_estado)
        IDLE: begin
          r_pend <= '0;
          if (bus.iniciar) begin
            r_nivel  <= '0;
            r_limpa  <= 1'b1;
            r_estado <= LIMPA;
          end
        end
        LIMPA: begin
          r_pend   <= '0;
          r_jog    <= '0;
          r_estado <= JOGANDO;
        end
        JOGANDO: begin
          r_pend <= (r_pend | w_rise) & ~w_sel;
          if (|r_pend) begin
            r_botoes <= w_sel;
            if (r_jog != 8'hFF) r_jog <= r_jog + 8'd1;
            r_espera <= 1'b0;
            r_estado <= AGUARDA;
          end
        end
        AGUARDA: begin
          r_espera <= 1'b1;
          if (r_espera) r_estado <= CHECA;
        end
        CHECA: begin
          if (!bus.nivel_concluido) begin
            r_estado <= JOGANDO;
          end else if (r_nivel == ULTIMO) begin
            r_venceu <= 1'b1;
            r_estado <= FIM;
          end else begin
            r_nivel  <= r_nivel + 3'd1;
            r_limpa  <= 1'b1;
            r_estado <= LIMPA;
          end
        end
        FIM: begin
          r_pend <= '0;
          if (bus.iniciar) begin
            r_nivel  <= '0;
            r_venceu <= 1'b0;
            r_limpa  <= 1'b1;
            r_estado <= LIMPA;
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign bus.botoes  = r_botoes;
  assign bus.limpa   = r_limpa;
  assign bus.nivel   = r_nivel;
  assign bus.jogadas = r_jog;
  assign bus.venceu  = r_venceu;
  assign bus.estado  = r_estado;
endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a registered win-flag matrix stub.
module tb_unidade_controle;
  import jogo_pkg::*;

  logic clk;
  logic rst_n;
  logic win_mode;
  logic r_ncl;

  int n_vec, n_err;
  int n_pulsos, n_limpa, n_multi;
  logic [7:0] pulsos[$];

  unidade_controle_if u_if();

  unidade_controle #(
    .DEBOUNCE_CYCLES (4),
    .N_NIVEIS        (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Matrix stub: win flag registered one cycle after a toggle, cleared by limpa.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_ncl <= 1'b0;
    else if (u_if.limpa)                     r_ncl <= 1'b0;
    else if (win_mode && u_if.botoes != 0)   r_ncl <= 1'b1;
  end
  assign u_if.nivel_concluido = r_ncl;

  always @(negedge clk) begin
    if (u_if.botoes != 8'h00) begin
      n_pulsos++;
      pulsos.push_back(u_if.botoes);
      if ($countones(u_if.botoes) != 1) n_multi++;
    end
    if (u_if.limpa) n_limpa++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic ciclo();
    @(negedge clk);
    #1;
  endtask

  task automatic espera_pulsos(input int alvo, input int limite);
    int c = 0;
    while (n_pulsos < alvo && c < limite) begin ciclo(); c++; end
    if (n_pulsos < alvo) chk("timeout_pulso", n_pulsos, alvo);
  endtask

  task automatic espera_estado(input logic [2:0] e, input int limite);
    int c = 0;
    while (u_if.estado != e && c < limite) begin ciclo(); c++; end
    if (u_if.estado != e) chk("timeout_estado", u_if.estado, e);
  endtask

  function automatic logic [7:0] pulso_em(input int i);
    return (pulsos.size() > i) ? pulsos[i] : 8'h00;
  endfunction

  initial begin
    int base, lc;
    clk = 0; rst_n = 1; win_mode = 0;
    n_vec = 0; n_err = 0; n_pulsos = 0; n_limpa = 0; n_multi = 0;
    u_if.iniciar = 0; u_if.botoes_raw = 8'h00;
    #1 rst_n = 0;
    #2;
    chk("rst_estado",  u_if.estado,  0);
    chk("rst_nivel",   u_if.nivel,   0);
    chk("rst_jogadas", u_if.jogadas, 0);
    chk("rst_venceu",  u_if.venceu,  0);
    chk("rst_botoes",  u_if.botoes,  0);
    chk("rst_limpa",   u_if.limpa,   0);
    repeat (2) ciclo();
    rst_n = 1;
    ciclo();
    chk("idle_hold", u_if.estado, 0);

    // start: one-cycle clear, then play
    u_if.iniciar = 1;
    ciclo();
    u_if.iniciar = 0;
    chk("ini_estado_limpa", u_if.estado, 1);
    chk("ini_limpa_hi",     u_if.limpa,  1);
    ciclo();
    chk("ini_estado_jog", u_if.estado,  2);
    chk("ini_limpa_lo",   u_if.limpa,   0);
    chk("ini_nivel",      u_if.nivel,   0);
    chk("ini_jogadas",    u_if.jogadas, 0);
    chk("ini_limpa_cnt",  n_limpa,      1);

    // two simultaneous presses, serviced lowest index first
    u_if.botoes_raw = 8'h05;
    espera_pulsos(2, 80);
    chk("p05_jogadas", u_if.jogadas, 2);
    chk("p05_first",   pulso_em(0),  8'h01);
    chk("p05_second",  pulso_em(1),  8'h04);
    u_if.botoes_raw = 8'h00;
    repeat (30) ciclo();
    chk("p05_count",  n_pulsos, 2);
    chk("p05_onehot", n_multi,  0);

    // bounce on bit 3 must yield a single press
    u_if.botoes_raw = 8'h08; ciclo();
    u_if.botoes_raw = 8'h00; ciclo();
    u_if.botoes_raw = 8'h08; ciclo();
    espera_pulsos(3, 80);
    repeat (30) ciclo();
    chk("bounce_count", n_pulsos,    3);
    chk("bounce_value", pulso_em(2), 8'h08);
    chk("bounce_jog",   u_if.jogadas, 3);
    u_if.botoes_raw = 8'h00;
    repeat (30) ciclo();

    // 300 more presses: jogadas saturates
    base = n_pulsos;
    for (int i = 0; i < 300; i++) begin
      u_if.botoes_raw = i[0] ? 8'h02 : 8'h01;
      espera_pulsos(base + i + 1, 60);
      if (i == 99) chk("sat_mid", u_if.jogadas, 103);
    end
    chk("sat_jogadas", u_if.jogadas, 255);
    chk("sat_onehot",  n_multi,      0);
    u_if.botoes_raw = 8'h00;
    repeat (30) ciclo();

    // each press now wins the level
    win_mode = 1;
    for (int lv = 1; lv < 5; lv++) begin
      lc = n_limpa;
      u_if.botoes_raw = 8'h01;
      espera_pulsos(n_pulsos + 1, 80);
      u_if.botoes_raw = 8'h00;
      espera_estado(3'd2, 20);
      chk("adv_nivel",   u_if.nivel,   lv);
      chk("adv_jogadas", u_if.jogadas, 0);
      chk("adv_limpa",   n_limpa,      lc + 1);
      repeat (30) ciclo();
    end
    u_if.botoes_raw = 8'h01;
    espera_pulsos(n_pulsos + 1, 80);
    u_if.botoes_raw = 8'h00;
    espera_estado(3'd5, 20);
    chk("fim_estado", u_if.estado, 5);
    chk("fim_venceu", u_if.venceu, 1);
    chk("fim_nivel",  u_if.nivel,  4);
    repeat (5) ciclo();
    chk("fim_hold", {u_if.estado, u_if.nivel, u_if.venceu}, {3'd5, 3'd4, 1'b1});

    lc = n_limpa;
    u_if.iniciar = 1;
    ciclo();
    u_if.iniciar = 0;
    win_mode = 0;
    chk("rei_estado", u_if.estado, 1);
    chk("rei_limpa",  u_if.limpa,  1);
    chk("rei_nivel",  u_if.nivel,  0);
    chk("rei_venceu", u_if.venceu, 0);
    ciclo();
    chk("rei_jogando", u_if.estado, 2);
    chk("rei_lcnt",    n_limpa,     lc + 1);
    repeat (30) ciclo();

    // reset in the middle of a toggle pulse
    u_if.botoes_raw = 8'h02;
    espera_pulsos(n_pulsos + 1, 80);
    chk("pre_rst_botoes", u_if.botoes, 8'h02);
    chk("pre_rst_estado", u_if.estado, 3);
    #1 rst_n = 0;
    #1;
    chk("arst_estado",  u_if.estado,  0);
    chk("arst_botoes",  u_if.botoes,  0);
    chk("arst_jogadas", u_if.jogadas, 0);
    chk("arst_limpa",   u_if.limpa,   0);
    chk("arst_venceu",  u_if.venceu,  0);
    chk("arst_nivel",   u_if.nivel,   0);
    lc = n_limpa;
    u_if.botoes_raw = 8'h00;
    repeat (3) ciclo();
    rst_n = 1;
    repeat (10) ciclo();
    chk("post_rst_idle",  u_if.estado, 0);
    chk("post_rst_nolim", n_limpa,     lc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
